// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/ack bus between the fetch stage and instruction
// memory.
//   imem_req   : fetch request, held with a stable address until acked
//   imem_addr  : fetch address (PC_W bits)
//   imem_ack   : word valid this cycle (meaningful only while imem_req=1)
//   imem_rdata : fetched instruction word (IR_W bits), valid with imem_ack
// The master modport is the fetch stage; the slave modport is the memory.
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int PC_W = 8,
  parameter int IR_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [IR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage directly upstream of decode. Owns the PC, fetches
// over a req/ack handshake, latches returned words into the decode
// instruction register and predecodes static (J/CALL) and register (JR/RET)
// jumps. A one-entry skid buffer absorbs a word that arrives while decode
// stalls; an execute redirect flushes the stage.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   imem (master)         : imem_req/imem_addr out, imem_ack/imem_rdata in
//   stall_in              : decode stall, IR holds
//   ex_redirect/ex_target : execute redirect and its new PC
//   ir_dec/pc_dec/ir_valid: instruction register, its PC, real-instruction flag
//   instr                 : opcode field of ir_dec
//   s_jump/r_jump         : ir_dec holds a static / register jump
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter int              IR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter logic [4:0]      J_OP     = 5'h0C,
  parameter logic [4:0]      CALL_OP  = 5'h0D,
  parameter logic [4:0]      JR_OP    = 5'h0E,
  parameter logic [4:0]      RET_OP   = 5'h0F
) (
  input  logic            clk,
  input  logic            reset,
  fetch_stage_if.master   imem,
  input  logic            stall_in,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  output logic [IR_W-1:0] ir_dec,
  output logic [PC_W-1:0] pc_dec,
  output logic            ir_valid,
  output logic [4:0]      instr,
  output logic            s_jump,
  output logic            r_jump
);

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_WAIT_R = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;        // address of the current / next request
  logic [PC_W-1:0] tgt_q, tgt_d;      // redirect target parked behind a dropped request
  logic            drop_q, drop_d;    // outstanding request's data must be discarded
  logic            req_q, req_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pcdec_q, pcdec_d;
  logic            irv_q, irv_d;
  logic [IR_W-1:0] buf_q, buf_d;
  logic [PC_W-1:0] bufpc_q, bufpc_d;
  logic            bufv_q, bufv_d;

  logic            ack_s;             // accepted ack
  logic            take_s;            // accepted ack whose word is kept
  logic            pend_s;            // request still outstanding after this cycle
  logic [4:0]      rd_op_s;
  logic [PC_W-1:0] rd_tgt_s;

  function automatic logic is_sjump(input logic [4:0] op);
    return (op == J_OP) || (op == CALL_OP);
  endfunction

  function automatic logic is_rjump(input logic [4:0] op);
    return (op == JR_OP) || (op == RET_OP);
  endfunction

  assign ack_s    = imem.imem_ack & req_q;
  assign take_s   = ack_s & ~drop_q;
  assign pend_s   = req_q & ~imem.imem_ack;
  assign rd_op_s  = imem.imem_rdata[4:0];
  assign rd_tgt_s = imem.imem_rdata[PC_W+4:5];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a fetched register jump parks the stage until a redirect.
  always_comb begin
    state_d = state_q;
    if (ex_redirect) begin
      state_d = ST_FETCH;
    end else if (take_s && is_rjump(rd_op_s)) begin
      state_d = ST_WAIT_R;
    end else begin
      state_d = state_q;
    end
  end

  // PC steering; a redirect during an outstanding request keeps the address
  // stable and parks the target until the stale ack returns.
  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    drop_d = drop_q;
    if (ex_redirect) begin
      if (pend_s) begin
        tgt_d  = ex_target;
        drop_d = 1'b1;
      end else begin
        pc_d   = ex_target;
        drop_d = 1'b0;
      end
    end else if (ack_s && drop_q) begin
      pc_d   = tgt_q;
      drop_d = 1'b0;
    end else if (take_s) begin
      if (is_sjump(rd_op_s)) begin
        pc_d = rd_tgt_s;
      end else if (is_rjump(rd_op_s)) begin
        pc_d = pc_q;
      end else begin
        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Instruction register and skid buffer: buffer first, then live ack, else NOP.
  always_comb begin
    ir_d    = ir_q;
    irv_d   = irv_q;
    pcdec_d = pcdec_q;
    buf_d   = buf_q;
    bufpc_d = bufpc_q;
    bufv_d  = bufv_q;
    if (ex_redirect) begin
      ir_d    = {IR_W{1'b0}};
      irv_d   = 1'b0;
      pcdec_d = {PC_W{1'b0}};
      bufv_d  = 1'b0;
    end else if (!stall_in) begin
      if (bufv_q) begin
        ir_d    = buf_q;
        pcdec_d = bufpc_q;
        irv_d   = 1'b1;
        bufv_d  = 1'b0;
      end else if (take_s) begin
        ir_d    = imem.imem_rdata;
        pcdec_d = pc_q;
        irv_d   = 1'b1;
      end else begin
        ir_d    = {IR_W{1'b0}};
        pcdec_d = {PC_W{1'b0}};
        irv_d   = 1'b0;
      end
    end else if (take_s) begin
      buf_d   = imem.imem_rdata;
      bufpc_d = pc_q;
      bufv_d  = 1'b1;
    end else begin
      bufv_d  = bufv_q;
    end
  end

  // Request for next cycle: keep an unacked request up, otherwise ask only
  // when fetching and the skid buffer will be empty.
  always_comb begin
    req_d = pend_s | ((state_d == ST_FETCH) & ~bufv_d);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      tgt_q   <= {PC_W{1'b0}};
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      ir_q    <= {IR_W{1'b0}};
      pcdec_q <= {PC_W{1'b0}};
      irv_q   <= 1'b0;
      buf_q   <= {IR_W{1'b0}};
      bufpc_q <= {PC_W{1'b0}};
      bufv_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      ir_q    <= ir_d;
      pcdec_q <= pcdec_d;
      irv_q   <= irv_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
      bufv_q  <= bufv_d;
    end
  end

  // Outputs, all driven from registers; jump flags predecode the IR opcode.
  always_comb begin
    imem.imem_req  = req_q;
    imem.imem_addr = pc_q;
    ir_dec         = ir_q;
    pc_dec         = pcdec_q;
    ir_valid       = irv_q;
    instr          = ir_q[4:0];
    s_jump         = irv_q & is_sjump(ir_q[4:0]);
    r_jump         = irv_q & is_rjump(ir_q[4:0]);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A program-level reference model walks
// the instruction memory (sequential, static jump, register-jump wait,
// redirect, stall buffering) and pushes every word decode must see into a
// scoreboard queue; a monitor pops and compares whenever a new word lands in
// the instruction register. Request/address behaviour is checked per cycle.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  localparam int         PC_W    = 8;
  localparam int         IR_W    = 16;
  localparam logic [4:0] J_OP    = 5'h0C;
  localparam logic [4:0] CALL_OP = 5'h0D;
  localparam logic [4:0] JR_OP   = 5'h0E;
  localparam logic [4:0] RET_OP  = 5'h0F;
  localparam logic [4:0] ADD_OP  = 5'h01;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stall_in = 1'b0;
  logic            ex_redirect = 1'b0;
  logic [PC_W-1:0] ex_target = 8'h00;
  logic [IR_W-1:0] ir_dec;
  logic [PC_W-1:0] pc_dec;
  logic            ir_valid;
  logic [4:0]      instr;
  logic            s_jump;
  logic            r_jump;

  fetch_stage_if #(.PC_W(PC_W), .IR_W(IR_W)) imem_bus ();

  fetch_stage #(.PC_W(PC_W), .IR_W(IR_W)) dut (
    .clk        (clk),
    .reset      (rst),
    .imem       (imem_bus),
    .stall_in   (stall_in),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .ir_dec     (ir_dec),
    .pc_dec     (pc_dec),
    .ir_valid   (ir_valid),
    .instr      (instr),
    .s_jump     (s_jump),
    .r_jump     (r_jump)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IR_W-1:0] w;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t            sb[$];
  logic [IR_W-1:0] mem [256];
  int              n_checks = 0;
  int              n_errors = 0;
  int              lat_lo = 0;
  int              lat_hi = 0;
  int              lat_left = -1;

  // reference model state
  bit              m_req = 1'b0;
  logic [PC_W-1:0] m_pc = 8'h00;
  logic [PC_W-1:0] m_tgt = 8'h00;
  bit              m_jr = 1'b0;
  bit              m_buf = 1'b0;
  bit              m_drop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IR_W-1:0] mk(input logic [4:0] op, input logic [PC_W-1:0] tgt);
    logic [2:0] hi;
    hi = 3'($urandom_range(0, 7));
    return {hi, tgt, op};
  endfunction

  function automatic logic [IR_W-1:0] rand_word();
    int r;
    logic [4:0] op;
    r = int'($urandom_range(0, 99));
    if (r < 5)       op = J_OP;
    else if (r < 8)  op = CALL_OP;
    else if (r < 11) op = JR_OP;
    else if (r < 13) op = RET_OP;
    else if (r < 50) op = 5'($urandom_range(0, 11));
    else             op = 5'($urandom_range(16, 31));
    return mk(op, 8'($urandom_range(0, 255)));
  endfunction

  // Program-level model of the edge that ends the current cycle.
  task automatic model_step(input bit ack, input bit st, input bit rd, input logic [PC_W-1:0] tg);
    logic [IR_W-1:0] w;
    bit acc;
    bit still_out;
    acc       = m_req && ack;
    still_out = m_req && !ack;
    if (rd) begin
      sb.delete();
      m_buf = 1'b0;
      m_jr  = 1'b0;
      if (still_out) begin
        m_drop = 1'b1;
        m_tgt  = tg;
      end else begin
        m_drop = 1'b0;
        m_pc   = tg;
      end
    end else begin
      if (!st) m_buf = 1'b0;
      if (acc && m_drop) begin
        m_drop = 1'b0;
        m_pc   = m_tgt;
      end else if (acc) begin
        w = mem[m_pc];
        sb.push_back('{w: w, pc: m_pc});
        case (w[4:0])
          J_OP, CALL_OP: m_pc = w[PC_W+4:5];
          JR_OP, RET_OP: m_jr = 1'b1;
          default:       m_pc = m_pc + 8'd1;
        endcase
        if (st) m_buf = 1'b1;
      end
    end
    m_req = still_out || (!m_jr && !m_buf);
  endtask

  // One clock cycle: check the request, play memory, drive decode/execute.
  task automatic cycle(input bit st, input bit rd, input logic [PC_W-1:0] tg);
    bit ack;
    @(negedge clk);
    #2;
    check("imem_req", 32'(imem_bus.imem_req), 32'(m_req));
    if (m_req) check("imem_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
    ack = 1'b0;
    if (imem_bus.imem_req) begin
      if (lat_left < 0) lat_left = int'($urandom_range(lat_lo, lat_hi));
      if (lat_left == 0) begin
        ack      = 1'b1;
        lat_left = -1;
      end else begin
        lat_left--;
      end
    end
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = ack ? mem[imem_bus.imem_addr] : 16'($urandom);
    stall_in    = st;
    ex_redirect = rd;
    ex_target   = tg;
    model_step(ack, st, rd, tg);
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    imem_bus.imem_ack = 1'b0;
    stall_in    = 1'b0;
    ex_redirect = 1'b0;
    #1;
    if (chk) begin
      check("rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
      check("rst_ir_dec",   32'(ir_dec),   32'd0);
      check("rst_pc_dec",   32'(pc_dec),   32'd0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_instr",    32'(instr),    32'd0);
      check("rst_s_jump",   32'(s_jump),   32'd0);
      check("rst_r_jump",   32'(r_jump),   32'd0);
    end
    sb.delete();
    m_req  = 1'b1;
    m_pc   = 8'h00;
    m_jr   = 1'b0;
    m_buf  = 1'b0;
    m_drop = 1'b0;
    lat_left = -1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Edge-time record of what the IR was allowed to do at the last edge.
  bit e_stall = 1'b0;
  bit e_redir = 1'b0;
  always @(posedge clk) begin
    e_stall <= stall_in;
    e_redir <= ex_redirect;
  end

  // Scoreboard monitor: compares each newly loaded IR word against the queue.
  logic [IR_W-1:0] held_ir = 16'h0000;
  logic            held_v  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (e_redir) begin
        check("redir_valid", 32'(ir_valid), 32'd0);
        check("redir_ir",    32'(ir_dec),   32'd0);
      end else if (e_stall) begin
        check("stall_ir",    32'(ir_dec),   32'(held_ir));
        check("stall_valid", 32'(ir_valid), 32'(held_v));
      end else if (ir_valid) begin
        if (sb.size() == 0) begin
          check("spurious_ir", 32'(ir_dec), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("ir_dec", 32'(ir_dec), 32'(e.w));
          check("pc_dec", 32'(pc_dec), 32'(e.pc));
          check("instr",  32'(instr),  32'(e.w[4:0]));
          check("s_jump", 32'(s_jump), 32'((e.w[4:0] == J_OP) || (e.w[4:0] == CALL_OP)));
          check("r_jump", 32'(r_jump), 32'((e.w[4:0] == JR_OP) || (e.w[4:0] == RET_OP)));
        end
      end else begin
        check("missing_ir", 32'(sb.size()), 32'd0);
        check("nop_ir",     32'(ir_dec),    32'd0);
      end
    end
    held_ir <= ir_dec;
    held_v  <= ir_valid;
  end

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = mk(ADD_OP, 8'($urandom_range(0, 255)));
    mem[8'h05] = mk(J_OP,  8'h40);
    mem[8'h45] = mk(J_OP,  8'h10);
    mem[8'h10] = mk(JR_OP, 8'h00);
    mem[8'h32] = mk(J_OP,  8'hFE);

    #1;
    do_reset(1'b1);

    // zero-wait sequential fetch, J 0x05->0x40, J 0x45->0x10, JR at 0x10 + 3 idle cycles
    repeat (16) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h22);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    // two-cycle stall across an ack, then release
    repeat (2) cycle(1'b1, 1'b0, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    // 3-cycle memory, redirect while a request is waiting
    lat_lo = 3;
    lat_hi = 3;
    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h30);
    repeat (10) cycle(1'b0, 1'b0, 8'h00);

    // zero-wait from 0x30: J to 0xFE, wrap 0xFF -> 0x00, on into the JR
    lat_lo = 0;
    lat_hi = 0;
    repeat (4) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h30);
    repeat (22) cycle(1'b0, 1'b0, 8'h00);

    // reset in the middle of a slow request
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 1'b1, 8'h50);
    cycle(1'b0, 1'b0, 8'h00);
    #1;
    do_reset(1'b1);

    // randomized program, latency, stalls and redirects
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    lat_lo = 0;
    lat_hi = 3;
    for (int n = 0; n < 3000; n++) begin
      bit st;
      bit rd;
      st = ($urandom_range(0, 99) < 20);
      rd = m_jr ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 3);
      cycle(st, rd, 8'($urandom_range(0, 255)));
      if (n == 1500) begin
        #1;
        do_reset(1'b1);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU, directly upstream of decode. Owns the PC and issues requests to instruction memory over a req/ack handshake. Latches each returned word into the decode instruction register and predecodes it into `s_jump`/`r_jump`, which decode uses to suppress its loads. A one-entry skid buffer absorbs a fetch that completes while decode is stalled; execute-stage redirects flush the stage.

## Interface
- `PC_W`, 8: PC / instruction-address width; must be ≤ `IR_W`−5.
- `IR_W`, 16: instruction width; opcode is `[4:0]`; static jump target is `[PC_W+4:5]`.
- `RESET_PC`, 0: PC value after reset.
- `J_OP`, 5'h0C and `CALL_OP`, 5'h0D: static-jump opcodes.
- `JR_OP`, 5'h0E and `RET_OP`, 5'h0F: register-jump opcodes.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch address; equals PC.
- `imem_ack`  in  1  word valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  IR_W  fetched word, valid with ack.
- `stall_in`  in  1  decode/hazard stall; IR must hold.
- `ex_redirect`  in  1  execute redirect (resolved JR/RET, taken branch).
- `ex_target`  in  PC_W  redirect PC.
- `ir_dec`  out  IR_W  instruction register to decode; NOP = all zeros.
- `pc_dec`  out  PC_W  PC of `ir_dec`.
- `ir_valid`  out  1  `ir_dec` holds a real instruction.
- `instr`  out  5  `ir_dec[4:0]`.
- `s_jump`  out  1  `ir_valid` and opcode ∈ {J_OP, CALL_OP}; combinational.
- `r_jump`  out  1  `ir_valid` and opcode ∈ {JR_OP, RET_OP}; combinational.

## Operation
- States:
  - FETCH: issuing or awaiting a fetch.
  - WAIT_R: register jump fetched; no requests until redirect.
- Request rule:
  - `imem_req`=1 in FETCH when the skid buffer is empty, or while a request is outstanding.
  - Once asserted, `imem_req` and `imem_addr` stay stable until the cycle `imem_ack`=1; a request is never withdrawn.
- On an accepted ack, PC steering uses a predecode of `imem_rdata`:
  - J/CALL: PC ← target field, zero-extended.
  - JR/RET: PC holds; state → WAIT_R.
  - Otherwise: PC ← PC+1, modulo 2^PC_W (all-ones wraps to 0).
- IR update on each cycle with `stall_in`=0, taking the first available source in this order:
  1. Skid buffer: load buffer word; buffer empties.
  2. Ack this cycle: load `imem_rdata`.
  3. Neither: load NOP with `ir_valid`=0.
  - `pc_dec` loads the PC of the word loaded.
- Ack while `stall_in`=1: word and its PC go to the skid buffer. `imem_req` drops until the buffer drains.
- Redirect (`ex_redirect`=1) has priority over stall, ack and buffer:
  - PC ← `ex_target`; IR ← NOP; `ir_valid` ← 0; buffer cleared; state → FETCH.
  - If a request is outstanding, it continues to ack and its data is discarded via an internal drop flag. The first request to `ex_target` issues the cycle after that ack.
- Redirect in WAIT_R is the normal exit path.

## Timing
- Reset values:
  - PC = `RESET_PC`; state FETCH; buffer empty; drop flag 0.
  - `imem_req`=0; `ir_dec`=0; `pc_dec`=0; `ir_valid`=0; `instr`=0; `s_jump`=`r_jump`=0.
  - The first request is raised in the first cycle after reset deasserts.
- Latency: with zero-wait memory (ack in the same cycle as req), the word is in `ir_dec` at the next edge. Sustained throughput is 1 instr/cycle.
- J/CALL: the target is requested the cycle after the jump's ack, with no bubble. Decode sees the jump itself with `s_jump`=1.
- JR/RET: no further fetch until redirect. Decode receives NOPs after the register jump.
- A redirect taking effect at edge N (no outstanding request) raises the `ex_target` request in cycle N+1.
- Reset mid-request abandons the request. `imem_req` goes low asynchronously.

## Test plan
- Reset, zero-wait memory with all-ADD program: `imem_addr` 0,1,2,… in consecutive cycles; `ir_valid`=1 from the second cycle; `pc_dec` trails `imem_addr` by one.
- J to 0x40 fetched at PC 0x05: next `imem_addr`=0x40; `s_jump`=1 for one cycle with `pc_dec`=0x05.
- JR at PC 0x10:
  - `r_jump`=1, then `imem_req`=0 and `ir_dec`=0 for 3 cycles.
  - Assert `ex_redirect` with target 0x22: next `imem_addr`=0x22.
- `stall_in`=1 for 2 cycles while an ack arrives: word held in buffer and `imem_req`=0. On release, `ir_dec` = buffered word, then fetch resumes at the next PC.
- Memory with 3-cycle ack latency:
  - `ex_redirect` to 0x30 during the wait: `imem_addr` stays stable until ack.
  - Acked data is discarded (`ir_valid`=0); the next request is 0x30.
- PC at 0xFF with `PC_W`=8, non-jump: next `imem_addr`=0x00. Assert `reset` mid-request: all outputs at reset values immediately.
